fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 4-bit processor. It owns the program counter, drives the instruction memory address, and registers the fetched word into the IF/ID pipeline register. It consumes the branch unit's resolution (`branchTaken`, `jumpAddress`): on a taken branch it redirects the PC and inserts a fixed number of bubbles so that no wrong-path instruction reaches decode.

## Interface
Parameters:
- `bus`, 4: PC and address width. Minimum 2.
- `INSTR_W`, 16: instruction word width.
- `FLUSH_CYCLES`, 1: bubbles inserted per taken branch. Legal range 1..3.

Ports:
- `clk`  in  1  system clock. Single clock domain, rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `stall`  in  1  holds the PC, the IF/ID register and the flush counter.
- `branchTaken`  in  1  taken branch, resolved by the branch unit this cycle.
- `jumpAddress`  in  bus  branch target; valid while `branchTaken`=1.
- `instrIn`  in  INSTR_W  instruction memory read data. Combinational from `imemAddr`.
- `imemAddr`  out  bus  instruction memory address (= PC register).
- `instrOut`  out  INSTR_W  IF/ID instruction.
- `pcOut`  out  bus  address of `instrOut`.
- `validOut`  out  1  1 = real instruction; 0 = bubble (decode treats it as NOP).
- `branchCount`, `bubbleCount`  out  8 each  present only with `FETCH_PERF_EN`.

## Operation
- **Reset** (`rst`=1 at an edge) sets:
  - PC=0, `instrOut`=NOP_INSTR (all zeros), `pcOut`=0, `validOut`=0.
  - state=RUN, flush counter=0, perf counters=0.
- **Priority at each edge:** rst > branchTaken > stall > normal.
- **RUN, no stall, no branch:**
  - `instrOut`<=`instrIn`, `pcOut`<=PC, `validOut`<=1.
  - PC<=PC+1, modulo 2^bus; 4'hF wraps to 4'h0 with no flag.
- **Taken branch** (`branchTaken`=1, any state, stall ignored):
  - PC<=`jumpAddress`.
  - `instrOut`<=NOP_INSTR, `validOut`<=0, `pcOut` holds.
  - If FLUSH_CYCLES>1: counter<=FLUSH_CYCLES-1, state<=FLUSH. Otherwise state<=RUN.
- **FLUSH, no stall, no branch:**
  - PC holds, `validOut`<=0, counter decrements.
  - When the counter reaches 0, state<=RUN.
- **Branch during FLUSH:** PC is re-targeted and the counter is reloaded. The newest branch wins.
- **stall=1** (no branch): every register holds, including the state and the counter.
- **Reset mid-flush:** the flush is abandoned. Next fetch is from address 0.

## Timing
- `imemAddr` is the PC register output. No combinational path from any input.
- Fetch latency is 1 cycle: the word at address A appears on `instrOut` at the edge after `imemAddr`=A.
- Branch sampled at edge N gives:
  - bubbles on `validOut` after edges N .. N+FLUSH_CYCLES-1;
  - the target instruction valid after edge N+FLUSH_CYCLES.
- First valid instruction after reset: the first edge with `rst`=0 and `stall`=0, with `pcOut`=0.
- `jumpAddress` is ignored unless `branchTaken`=1.

## Configuration
- `FETCH_PERF_EN` defined:
  - `branchCount` increments on each accepted taken branch.
  - `bubbleCount` increments on each edge that loads `validOut`=0, excluding reset and stall edges.
  - Both counters saturate at 8'hFF and clear on reset.
- `FETCH_PERF_EN` undefined: both ports and their registers are absent. Fetch behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {RUN, FLUSH};
  - `NOP_INSTR` constant (all zeros);
  - `FLUSH_MAX`=3.
- One sub-module, `fetch_flush_ctrl`: the FSM plus the flush counter.
  - Inputs: `clk`, `rst`, `stall`, `branchTaken`.
  - Outputs: `bubble`, `holdPC`.
- The PC and IF/ID registers stay in `fetch_unit`.

## Test plan
- Reset, then 3 free-running cycles with memory word = 16'h1000+address:
  - `pcOut` = 0, 1, 2;
  - `instrOut` = 16'h1000, 16'h1001, 16'h1002;
  - `validOut`=1 from the first edge after reset.
- PC=4'hF, no stall → `instrOut`=16'h100F, then PC wraps to 0 and the next `pcOut`=0.
- FLUSH_CYCLES=2, branchTaken with jumpAddress=4'h9 at PC=3:
  - `validOut`=0 for 2 cycles;
  - then `pcOut`=9, `instrOut`=16'h1009, `validOut`=1.
- stall=1 for 2 cycles at PC=5 → `imemAddr`, `instrOut` and `pcOut` frozen; the fetch resumes at 5.
- Branch to 4'h2 during FLUSH, then branchTaken+stall together to 4'h7 → both redirects accepted; the final valid `pcOut`=7.
- `rst`=1 mid-flush → all outputs at reset values; the next fetch has `pcOut`=0. With `FETCH_PERF_EN` also check `branchCount`/`bubbleCount` values and saturation at 8'hFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // Largest supported number of bubbles per taken branch
    localparam int FLUSH_MAX = 3;

    // Width of the flush counter, sized for FLUSH_MAX-1
    localparam int FLUSH_CNT_W = 2;

    // Bubble instruction word; sliced down to the instruction width in use
    localparam logic [63:0] NOP_INSTR = 64'h0;

endpackage

// File: rtl/fetch_flush_ctrl.sv
// rtl/fetch_flush_ctrl.sv - branch flush FSM and bubble counter for the fetch stage
module fetch_flush_ctrl
    import fetch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic branchTaken,
    output logic bubble,
    output logic holdPC
);

    fetch_state_t           state_q;
    logic [FLUSH_CNT_W-1:0] cnt_q;

    // The first bubble is produced by the branch edge itself, so only
    // FLUSH_CYCLES-1 further edges are spent in FLUSH.
    localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    // Flush FSM: newest branch reloads, stall freezes, counter runs down to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (branchTaken) begin
            if (FLUSH_CYCLES > 1) begin
                state_q <= FLUSH;
                cnt_q   <= RELOAD;
            end else begin
                state_q <= RUN;
                cnt_q   <= '0;
            end
        end else if (!stall && state_q == FLUSH) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == FLUSH_CNT_W'(1)) begin
                state_q <= RUN;
            end
        end
    end

    // While flushing the PC already points at the target and the IF/ID
    // register must keep receiving bubbles.
    assign bubble = (state_q == FLUSH);
    assign holdPC = (state_q == FLUSH);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem address, IF/ID register (optional FETCH_PERF_EN counters)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int bus          = 4,
    parameter int INSTR_W      = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branchTaken,
    input  logic [bus-1:0]     jumpAddress,
    input  logic [INSTR_W-1:0] instrIn,
    output logic [bus-1:0]     imemAddr,
    output logic [INSTR_W-1:0] instrOut,
    output logic [bus-1:0]     pcOut,
`ifdef FETCH_PERF_EN
    output logic               validOut,
    output logic [7:0]         branchCount,
    output logic [7:0]         bubbleCount
`else
    output logic               validOut
`endif
);

    localparam logic [INSTR_W-1:0] NOP_W = NOP_INSTR[INSTR_W-1:0];

    logic               bubble;
    logic               hold_pc;

    logic [bus-1:0]     pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [bus-1:0]     pcout_q, pcout_d;
    logic               valid_q, valid_d;

    fetch_flush_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_ctrl (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branchTaken (branchTaken),
        .bubble      (bubble),
        .holdPC      (hold_pc)
    );

    // Next-state select: branch beats stall, stall beats flush and normal fetch
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        if (branchTaken) begin
            pc_d    = jumpAddress;
            instr_d = NOP_W;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (bubble || hold_pc) begin
            instr_d = NOP_W;
            valid_d = 1'b0;
        end else begin
            instr_d = instrIn;
            pcout_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
        end
    end

    // PC and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_W;
            pcout_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
        end
    end

    assign imemAddr = pc_q;
    assign instrOut = instr_q;
    assign pcOut    = pcout_q;
    assign validOut = valid_q;

`ifdef FETCH_PERF_EN
    logic [7:0] branch_cnt_q;
    logic [7:0] bubble_cnt_q;
    logic       bubble_edge;

    assign bubble_edge = branchTaken || (!stall && (bubble || hold_pc));

    // Saturating counters of accepted branches and bubble-loading edges
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (branchTaken && branch_cnt_q != 8'hFF) begin
                branch_cnt_q <= branch_cnt_q + 8'd1;
            end
            if (bubble_edge && bubble_cnt_q != 8'hFF) begin
                bubble_cnt_q <= bubble_cnt_q + 8'd1;
            end
        end
    end

    assign branchCount = branch_cnt_q;
    assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [3:0]  jumpAddress;
    logic [15:0] instrIn;
    logic [3:0]  imemAddr;
    logic [15:0] instrOut;
    logic [3:0]  pcOut;
    logic        validOut;
`ifdef FETCH_PERF_EN
    logic [7:0]  branchCount;
    logic [7:0]  bubbleCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .bus          (4),
        .INSTR_W      (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branchTaken (branchTaken),
        .jumpAddress (jumpAddress),
        .instrIn     (instrIn),
        .imemAddr    (imemAddr),
        .instrOut    (instrOut),
        .pcOut       (pcOut),
`ifdef FETCH_PERF_EN
        .validOut    (validOut),
        .branchCount (branchCount),
        .bubbleCount (bubbleCount)
`else
        .validOut    (validOut)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address A is 16'h1000 + A
    assign instrIn = 16'h1000 + {12'h000, imemAddr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_addr,
                             input logic [15:0] e_instr, input logic [3:0] e_pc,
                             input logic e_valid);
        check_eq({tag, ".imemAddr"}, {28'h0, imemAddr}, {28'h0, e_addr});
        check_eq({tag, ".instrOut"}, {16'h0, instrOut}, {16'h0, e_instr});
        check_eq({tag, ".pcOut"},    {28'h0, pcOut},    {28'h0, e_pc});
        check_eq({tag, ".validOut"}, {31'h0, validOut}, {31'h0, e_valid});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; jumpAddress = 4'h0;
        tick; tick;
        check_out("reset", 4'h0, 16'h0000, 4'h0, 1'b0);
`ifdef FETCH_PERF_EN
        check_eq("reset.branchCount", {24'h0, branchCount}, 32'd0);
        check_eq("reset.bubbleCount", {24'h0, bubbleCount}, 32'd0);
`endif

        // Free run; jumpAddress garbage must be ignored without branchTaken
        #3 rst = 1'b0; jumpAddress = 4'hC;
        tick; check_out("run0", 4'h1, 16'h1000, 4'h0, 1'b1);
        tick; check_out("run1", 4'h2, 16'h1001, 4'h1, 1'b1);
        tick; check_out("run2", 4'h3, 16'h1002, 4'h2, 1'b1);

        // Branch to 9 at PC=3: two bubbles, then target valid
        #3 branchTaken = 1'b1; jumpAddress = 4'h9;
        tick; check_out("br9.b0", 4'h9, 16'h0000, 4'h2, 1'b0);
        #3 branchTaken = 1'b0; jumpAddress = 4'h0;
        tick; check_out("br9.b1", 4'h9, 16'h0000, 4'h2, 1'b0);
        tick; check_out("br9.tgt", 4'hA, 16'h1009, 4'h9, 1'b1);

        // Branch to E, then run through the F->0 wrap
        #3 branchTaken = 1'b1; jumpAddress = 4'hE;
        tick;
        #3 branchTaken = 1'b0;
        tick; check_eq("brE.b1.valid", {31'h0, validOut}, 32'd0);
        tick; check_out("brE.tgt", 4'hF, 16'h100E, 4'hE, 1'b1);
        tick; check_out("wrapF", 4'h0, 16'h100F, 4'hF, 1'b1);
        tick; check_out("wrap0", 4'h1, 16'h1000, 4'h0, 1'b1);
        tick; tick; tick; tick;
        check_out("pre_stall", 4'h5, 16'h1004, 4'h4, 1'b1);

        // Stall two cycles at PC=5: everything frozen, then resume at 5
        #3 stall = 1'b1;
        tick; check_out("stall0", 4'h5, 16'h1004, 4'h4, 1'b1);
        tick; check_out("stall1", 4'h5, 16'h1004, 4'h4, 1'b1);
        #3 stall = 1'b0;
        tick; check_out("resume", 4'h6, 16'h1005, 4'h5, 1'b1);

        // Branch to 2, then branch+stall to 7 during the flush: newest wins
        #3 branchTaken = 1'b1; jumpAddress = 4'h2;
        tick; check_out("br2", 4'h2, 16'h0000, 4'h5, 1'b0);
        #3 stall = 1'b1; jumpAddress = 4'h7;
        tick; check_out("br7st", 4'h7, 16'h0000, 4'h5, 1'b0);
        #3 stall = 1'b0; branchTaken = 1'b0;
        tick; check_out("br7.b1", 4'h7, 16'h0000, 4'h5, 1'b0);
        tick; check_out("br7.tgt", 4'h8, 16'h1007, 4'h7, 1'b1);

        // Reset in the middle of a flush
        #3 branchTaken = 1'b1; jumpAddress = 4'hB;
        tick;
        check_eq("brB.addr", {28'h0, imemAddr}, 32'hB);
`ifdef FETCH_PERF_EN
        check_eq("perf.branchCount", {24'h0, branchCount}, 32'd5);
        check_eq("perf.bubbleCount", {24'h0, bubbleCount}, 32'd8);
`endif
        #3 branchTaken = 1'b0; rst = 1'b1;
        tick; check_out("midrst", 4'h0, 16'h0000, 4'h0, 1'b0);
`ifdef FETCH_PERF_EN
        check_eq("midrst.branchCount", {24'h0, branchCount}, 32'd0);
        check_eq("midrst.bubbleCount", {24'h0, bubbleCount}, 32'd0);
`endif
        #3 rst = 1'b0;
        tick; check_out("after_rst", 4'h1, 16'h1000, 4'h0, 1'b1);

`ifdef FETCH_PERF_EN
        // Saturation: 260 back-to-back branches
        #3 branchTaken = 1'b1; jumpAddress = 4'h0;
        for (int i = 0; i < 260; i++) tick;
        check_eq("sat.branchCount", {24'h0, branchCount}, 32'hFF);
        check_eq("sat.bubbleCount", {24'h0, bubbleCount}, 32'hFF);
        #3 branchTaken = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
